// File: rtl/node_state_tally.sv
`default_nettype none
// ============================================================================
// node_state_tally : per-node "ticks infected" tally with a streamed dump.
// Revision 1.0
// ============================================================================
module node_state_tally #(
    parameter int NUM_NODES = 100,
    parameter int CNT_W     = 32,
    parameter int IDX_W     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_NODES-1:0] states,
    input  logic                 tickEn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 dumpReq,
    output logic                 running,
    output logic                 dumping,
    output logic [CNT_W-1:0]     tickCount,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [IDX_W-1:0]     outIndex,
    output logic [CNT_W-1:0]     outData,
    output logic                 outLast
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    state_t           state;
    logic             ret_run;
    logic             clear_all;
    logic             sample;
    logic             xfer;
    logic [CNT_W-1:0] cnt_q [NUM_NODES];

    // start is honoured everywhere except DUMP, and it discards that edge's sample
    assign clear_all = start && (state != ST_DUMP);
    assign sample    = (state == ST_RUN) && tickEn && !start;
    assign xfer      = dumping && outReady;

    generate
        for (genvar i = 0; i < NUM_NODES; i++) begin : g_node_cnt
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear_all) begin
                    cnt <= '0;
                end else if (sample && states[i] && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign cnt_q[i] = cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ret_run   <= 1'b0;
            tickCount <= '0;
            outIndex  <= '0;
            running   <= 1'b0;
            dumping   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tickCount <= '0;
                        state     <= ST_RUN;
                        running   <= 1'b1;
                    end else if (dumpReq) begin
                        ret_run  <= 1'b0;
                        outIndex <= '0;
                        state    <= ST_DUMP;
                        dumping  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        tickCount <= '0;
                    end else begin
                        if (sample && (tickCount != CNT_MAX)) begin
                            tickCount <= tickCount + 1'b1;
                        end
                        if (dumpReq) begin
                            ret_run  <= 1'b1;
                            outIndex <= '0;
                            state    <= ST_DUMP;
                            running  <= 1'b0;
                            dumping  <= 1'b1;
                        end else if (stop) begin
                            state   <= ST_IDLE;
                            running <= 1'b0;
                        end
                    end
                end
                ST_DUMP: begin
                    if (xfer) begin
                        if (outIndex == LAST_IDX) begin
                            outIndex <= '0;
                            dumping  <= 1'b0;
                            running  <= ret_run;
                            state    <= ret_run ? ST_RUN : ST_IDLE;
                        end else begin
                            outIndex <= outIndex + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    dumping <= 1'b0;
                end
            endcase
        end
    end

    // Counters are frozen during DUMP, so a plain mux gives stable data under stalls
    assign outValid = dumping;
    assign outData  = cnt_q[outIndex];
    assign outLast  = dumping && (outIndex == LAST_IDX);

endmodule
`default_nettype wire

// File: doc/node_state_tally.md
Name: node_state_tally

Overview:
- Reader-side counterpart to the network's per-tick state output.
- Samples the NUM_NODES-wide node state vector once per enabled tick.
- Keeps one saturating "ticks infected" counter per node and a global tick counter.
- On request, streams every per-node count over a valid/ready interface, so on-chip runs can be summarised without simulator file logging.

Parameters:
- NUM_NODES, 100, width of the sampled state vector and number of per-node counters.
- CNT_W, 32, width of each per-node counter and of the tick counter.
- IDX_W, 7, width of the node index; must satisfy 2**IDX_W >= NUM_NODES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- states  in  NUM_NODES  current node states from the network; bit i = 1 means node i is infected.
- tickEn  in  1  sample `states` this cycle (network advanced one tick).
- start  in  1  pulse: clear all counters and begin tallying.
- stop  in  1  pulse: stop tallying; counters hold.
- dumpReq  in  1  pulse: stream all per-node counts.
- running  out  1  high in RUN state.
- dumping  out  1  high in DUMP state.
- tickCount  out  CNT_W  number of sampled ticks since the last start.
- outValid  out  1  stream data valid.
- outReady  in  1  stream sink ready.
- outIndex  out  IDX_W  node index of the current word.
- outData  out  CNT_W  per-node count for outIndex.
- outLast  out  1  high with the word for index NUM_NODES-1.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; all per-node counters, tickCount and outIndex = 0.
  - running = dumping = outValid = outLast = 0.
  - Reset mid-dump aborts the stream immediately with no completion.
- State machine: IDLE, RUN, DUMP, plus a 1-bit retState (IDLE or RUN) that records where DUMP returns to.
- IDLE:
  - start → clear all counters and tickCount, go to RUN.
  - Else dumpReq → retState = IDLE, go to DUMP.
  - stop is ignored. Counters hold.
- RUN:
  - Each edge with tickEn=1: tickCount += 1, and count[i] += states[i] for every node i.
  - Both counter types saturate at 2**CNT_W-1 and never wrap.
  - Priority on the same edge: start > dumpReq > stop.
  - start clears all counters and stays in RUN. The tickEn sample on that edge is discarded.
  - dumpReq → retState = RUN, go to DUMP. The tickEn sample on that edge is still counted.
  - stop → IDLE. The tickEn sample on that edge is still counted.
- DUMP:
  - Sampling is frozen: tickEn, start, stop and dumpReq are all ignored.
  - outValid = 1 from the first cycle in DUMP.
  - outIndex starts at 0; outData = count[outIndex], driven combinationally from the frozen counters.
  - outLast = (outIndex == NUM_NODES-1).
  - Transfer happens on an edge with outValid && outReady; outIndex then increments.
  - While outReady = 0, outIndex, outData and outLast are held stable.
  - On the transfer with outLast = 1: outIndex → 0, state → retState, outValid = 0 on the next cycle.
  - No gap cycles are inserted: with outReady held at 1, NUM_NODES words take exactly NUM_NODES cycles.
- Outputs: running = (state == RUN); dumping = (state == DUMP). tickCount is updated registered, one edge after the sample.
- A dump does not clear counters. A subsequent dump repeats the same values unless RUN has continued in between.
- NUM_NODES == 2**IDX_W is legal; outIndex still wraps to 0 only via the outLast rule.

Test Plan:
1. Reset, start, 10 cycles with tickEn=1 and states=1 (bit 0 only), stop, then dumpReq with outReady=1:
   - tickCount = 10.
   - Words: index 0 = 10, indices 1..99 = 0.
   - outLast only at index 99.
   - Exactly 100 consecutive valid cycles, then IDLE.
2. RUN with tickEn toggling 1,0,1,0,... for 8 cycles and states = all ones:
   - tickCount = 4; every node count = 4.
3. Dump with outReady pattern 1,0,0,1,... :
   - outIndex and outData stable during stalls.
   - All 100 words delivered in order; no duplicate or skipped index.
4. dumpReq while RUN at tickCount = 5 with tickEn=1 on that edge:
   - Dumped counts and tickCount reflect 6 ticks.
   - tickEn during DUMP is not counted.
   - running = 1 again after the last word and counting resumes.
5. Saturation with CNT_W=4, tickEn=1 and states bit 3 = 1 for 20 ticks:
   - count[3] = 15 and tickCount = 15; neither wraps.
6. Assert rst_n = 0 mid-dump at outIndex = 40:
   - outValid drops immediately.
   - After release: IDLE, all counts 0; a dump returns 100 zeros.
